chip_bus_arbiter: RTL
=====================

# chip_bus_arbiter

Slot-level arbiter for the A1000 chip-RAM bus: one memory cycle per colour clock, allocated per scanline position between refresh, disk, audio, sprite, bitplane, copper, blitter and 68000 requesters. Sits inside the Agnus model. Drives the grant code that the address generator and the CPU wait-state logic consume.

## Interface
- HMAX, 8'hE2: last slot of a short line; a line is 0..HMAX, or 0..HMAX+1 when LOL=1.
- CPU_STARVE_MAX, 3: consecutive blitter-won slots tolerated against a waiting CPU before the CPU is forced in (BLTPRI=0).
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- CCK_EN  in  1  colour-clock strobe; arbitration and HPOS advance only on CLK edges with CCK_EN=1.
- LOL  in  1  long-line select, sampled when HPOS==HMAX.
- DMAEN, DSKEN, SPREN, BPLEN, COPEN, BLTEN, BLTPRI  in  1 each  DMACON bits.
- AUDEN  in  4  audio channel enables.
- DSK_REQ, BPL_REQ, COP_REQ, BLT_REQ, CPU_REQ  in  1 each  requests, level-sensitive.
- AUD_REQ  in  4  per-channel audio requests.
- SPR_REQ  in  8  per-sprite requests.
- HPOS  out  8  slot number of the current grant.
- GNT  out  4  0 idle, 1 refresh, 2 disk, 3 audio, 4 sprite, 5 bitplane, 6 copper, 7 blitter, 8 CPU.
- GNT_IDX  out  3  channel index for refresh (0-3), audio (0-3), sprite (0-7); 0 otherwise.
- LINE_END  out  1  high for the slot where HPOS==0 following a wrap.
- CPU_WAIT  out  1  CPU_REQ=1 and GNT!=8, combinational on registered GNT.

## Operation
- On CCK_EN edge: HPOS_n = HPOS+1, or 0 if HPOS==HMAX+LOL_latched. GNT/GNT_IDX are computed from HPOS_n and the current requests, then registered together with HPOS.
- Fixed odd slots, by HPOS_n:
  - 0x01/03/05/07: refresh 0-3. Always granted and not gated by DMAEN.
  - 0x09/0B/0D: disk if DMAEN&DSKEN&DSK_REQ.
  - 0x0F/11/13/15: audio ch 0-3 if DMAEN&AUDEN[n]&AUD_REQ[n].
  - 0x17..0x35 odd: sprite n=(HPOS_n-0x17)>>2, if DMAEN&SPREN&SPR_REQ[n]. Bitplane (DMAEN&BPLEN&BPL_REQ) pre-empts sprite slots.
- Free slots (fixed owner not requesting, a sprite slot not taken, or any other HPOS) resolve in this order:
  - bitplane;
  - copper (DMAEN&COPEN&COP_REQ, even HPOS_n only, never 0xE0);
  - blitter (DMAEN&BLTEN&BLT_REQ), subject to the nasty rule;
  - CPU;
  - idle.
- Refresh/disk/audio slots never go to bitplane.
- Nasty rule: starve counter 0..CPU_STARVE_MAX.
  - Increments when blitter wins a slot while CPU_REQ=1 and BLTPRI=0.
  - At CPU_STARVE_MAX with CPU_REQ=1, the next slot that would go to the blitter goes to the CPU instead.
  - Clears on CPU grant, on CPU_REQ=0, or while BLTPRI=1.
  - BLTPRI=1: blitter always beats CPU.
- DMAEN=0: only refresh and CPU slots are granted.

## Timing
- Reset: HPOS=0, GNT=0, GNT_IDX=0, LINE_END=0, starve counter=0, LOL_latched=0. CPU_WAIT follows CPU_REQ.
- Reset mid-line aborts the current grant the next CLK. The first CCK_EN after reset produces HPOS=1 (refresh 0).
- Decision latency: one CLK from the CCK_EN edge. Outputs are held between strobes.
- Requests are sampled only on CCK_EN edges. A request that drops between strobes does not affect the held grant.
- LOL is latched at the HMAX slot. A change elsewhere affects the next line only.
- LINE_END asserts with HPOS=0 and clears on the next strobe.

## Test plan
- Reset, no requests, 228 strobes, LOL=0 → refresh at HPOS 1,3,5,7 with GNT_IDX 0-3; all other slots idle; HPOS wraps 0xE2→0 with LINE_END=1.
- LOL=1 at HMAX → HPOS reaches 0xE3 before 0; next line with LOL=0 stops at 0xE2.
- DMAEN=SPREN=BPLEN=1, SPR_REQ=8'hFF, BPL_REQ=1 → slots 0x17-0x35 odd go to bitplane (GNT=5); BPL_REQ=0 → slot 0x1B grants sprite with GNT_IDX=1.
- COP_REQ only → copper on even slots, never 0xE0 or odd slots; AUD_REQ=4'b0100 with AUDEN → GNT=3, IDX=2 at HPOS 0x13.
- BLT_REQ and CPU_REQ constant, BLTPRI=0 → pattern blitter, blitter, blitter, CPU repeating on free slots, CPU_WAIT high during blitter slots; BLTPRI=1 → CPU never granted.
- RST pulse at HPOS 0x40 during a blitter grant → next CLK GNT=0, HPOS=0, starve counter 0; the next strobe yields HPOS=1, GNT=1.

Source files
------------

// File: rtl/chip_bus_arbiter_if.sv
// Chip-RAM bus arbitration signals: DMACON bits, requests and the grant code.
// The master side (the requesters) drives the controls; the slave side is the arbiter.
interface chip_bus_arbiter_if;
  logic       cck_en;
  logic       lol;
  logic       dmaen;
  logic       dsken;
  logic       spren;
  logic       bplen;
  logic       copen;
  logic       blten;
  logic       bltpri;
  logic [3:0] auden;
  logic       dsk_req;
  logic       bpl_req;
  logic       cop_req;
  logic       blt_req;
  logic       cpu_req;
  logic [3:0] aud_req;
  logic [7:0] spr_req;
  logic [7:0] hpos;
  logic [3:0] gnt;
  logic [2:0] gnt_idx;
  logic       line_end;
  logic       cpu_wait;

  modport master (
    output cck_en, lol, dmaen, dsken, spren, bplen, copen, blten, bltpri, auden,
           dsk_req, bpl_req, cop_req, blt_req, cpu_req, aud_req, spr_req,
    input  hpos, gnt, gnt_idx, line_end, cpu_wait
  );

  modport slave (
    input  cck_en, lol, dmaen, dsken, spren, bplen, copen, blten, bltpri, auden,
           dsk_req, bpl_req, cop_req, blt_req, cpu_req, aud_req, spr_req,
    output hpos, gnt, gnt_idx, line_end, cpu_wait
  );
endinterface

// File: rtl/chip_bus_arbiter.sv
// Per-colour-clock chip-RAM slot arbiter: fixed odd slots for refresh/disk/audio/sprite,
// free slots shared by bitplane, copper, blitter and CPU with the blitter-nasty limit.
module chip_bus_arbiter #(
  parameter logic [7:0]  Hmax         = 8'hE2,
  parameter int unsigned CpuStarveMax = 3
) (
  input logic               clk,
  input logic               rst,
  chip_bus_arbiter_if.slave bus
);

  localparam int unsigned StW = $clog2(CpuStarveMax + 1);

  typedef enum logic [3:0] {
    GntIdle    = 4'd0,
    GntRefresh = 4'd1,
    GntDisk    = 4'd2,
    GntAudio   = 4'd3,
    GntSprite  = 4'd4,
    GntBpl     = 4'd5,
    GntCop     = 4'd6,
    GntBlt     = 4'd7,
    GntCpu     = 4'd8
  } gnt_e;

  logic [7:0]     hpos_q, hpos_d;
  gnt_e           gnt_q, gnt_d;
  logic [2:0]     gnt_idx_q, gnt_idx_d;
  logic           line_end_q, line_end_d;
  logic           lol_q, lol_d;
  logic [StW-1:0] starve_q, starve_d;

  logic       lol_eff, wrap;
  logic [7:0] hn;
  logic       is_ref, is_dsk, is_aud, is_spr;
  logic [1:0] aud_ch;
  logic [2:0] spr_n;
  logic       bpl_ok, cop_ok, blt_ok, force_cpu;
  logic       free, no_bpl;

  // Line length is decided by LOL as seen during the HMAX slot itself.
  always_comb begin
    lol_eff    = (hpos_q == Hmax) ? bus.lol : lol_q;
    wrap       = hpos_q >= (Hmax + {7'd0, lol_eff});
    hn         = wrap ? 8'd0 : hpos_q + 8'd1;
    hpos_d     = hn;
    lol_d      = lol_eff;
    line_end_d = wrap;
  end

  always_comb begin
    is_ref = (hn[7:3] == 5'd0) && hn[0];
    is_dsk = (hn == 8'h09) || (hn == 8'h0B) || (hn == 8'h0D);
    is_aud = hn[0] && (hn >= 8'h0F) && (hn <= 8'h15);
    is_spr = hn[0] && (hn >= 8'h17) && (hn <= 8'h35);
    aud_ch = 2'((hn - 8'h0F) >> 1);
    spr_n  = 3'((hn - 8'h17) >> 2);
    bpl_ok = bus.dmaen && bus.bplen && bus.bpl_req;
    cop_ok = bus.dmaen && bus.copen && bus.cop_req && !hn[0] && (hn != 8'hE0);
    blt_ok = bus.dmaen && bus.blten && bus.blt_req;
    force_cpu = !bus.bltpri && bus.cpu_req && (starve_q == StW'(CpuStarveMax));
  end

  always_comb begin
    gnt_d     = GntIdle;
    gnt_idx_d = 3'd0;
    free      = 1'b0;
    no_bpl    = 1'b0;
    if (is_ref) begin
      gnt_d     = GntRefresh;
      gnt_idx_d = {1'b0, hn[2:1]};
    end else if (is_dsk) begin
      if (bus.dmaen && bus.dsken && bus.dsk_req) begin
        gnt_d = GntDisk;
      end else begin
        free   = 1'b1;
        no_bpl = 1'b1;
      end
    end else if (is_aud) begin
      if (bus.dmaen && bus.auden[aud_ch] && bus.aud_req[aud_ch]) begin
        gnt_d     = GntAudio;
        gnt_idx_d = {1'b0, aud_ch};
      end else begin
        free   = 1'b1;
        no_bpl = 1'b1;
      end
    end else if (is_spr) begin
      if (bpl_ok) begin
        gnt_d = GntBpl;
      end else if (bus.dmaen && bus.spren && bus.spr_req[spr_n]) begin
        gnt_d     = GntSprite;
        gnt_idx_d = spr_n;
      end else begin
        free = 1'b1;
      end
    end else begin
      free = 1'b1;
    end

    if (free) begin
      if (bpl_ok && !no_bpl) begin
        gnt_d = GntBpl;
      end else if (cop_ok) begin
        gnt_d = GntCop;
      end else if (blt_ok && !force_cpu) begin
        gnt_d = GntBlt;
      end else if (bus.cpu_req) begin
        gnt_d = GntCpu;
      end else begin
        gnt_d = GntIdle;
      end
    end
  end

  // Starve count only tracks blitter wins against a waiting, lower-priority CPU.
  always_comb begin
    starve_d = starve_q;
    if (bus.bltpri || !bus.cpu_req || (gnt_d == GntCpu)) begin
      starve_d = '0;
    end else if ((gnt_d == GntBlt) && (starve_q != StW'(CpuStarveMax))) begin
      starve_d = starve_q + StW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q     <= 8'd0;
      gnt_q      <= GntIdle;
      gnt_idx_q  <= 3'd0;
      line_end_q <= 1'b0;
      lol_q      <= 1'b0;
      starve_q   <= '0;
    end else if (bus.cck_en) begin
      hpos_q     <= hpos_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      line_end_q <= line_end_d;
      lol_q      <= lol_d;
      starve_q   <= starve_d;
    end
  end

  assign bus.hpos     = hpos_q;
  assign bus.gnt      = gnt_q;
  assign bus.gnt_idx  = gnt_idx_q;
  assign bus.line_end = line_end_q;
  assign bus.cpu_wait = bus.cpu_req && (gnt_q != GntCpu);

endmodule
